// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: Diff = A - B - Bin, one 4-bit lookahead nibble per cycle.
// Optional macro SUB_OVERFLOW_EN adds the registered signed-overflow output Ovf.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q, bout_q, zero_q;
    logic             load_op, last_nib;
    logic [3:0]       a_nib, b_nib, g, p, nib_diff;
    logic [4:0]       c;

    assign a_nib    = a_q[{cnt_q, 2'b00} +: 4];
    assign b_nib    = b_q[{cnt_q, 2'b00} +: 4];
    assign last_nib = (cnt_q == LAST);
    assign load_op  = Start && (state_q != RUN);

    // Borrow lookahead: every nibble borrow is a flat sum of products of g, p and borrow_q.
    assign g = ~a_nib & b_nib;
    assign p = ~(a_nib ^ b_nib);
    assign c[0] = borrow_q;
    assign c[1] = g[0] | (p[0] & borrow_q);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & borrow_q);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & borrow_q);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & borrow_q);
    assign nib_diff = a_nib ^ b_nib ^ c[3:0];

    always_comb begin
        // NOTE: default assignment first so no path through the block leaves acc_d unassigned (no latch).
        acc_d = acc_q;
        acc_d[{cnt_q, 2'b00} +: 4] = nib_diff;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = RUN;
            RUN:     if (last_nib) state_d = DONE;
            DONE:    state_d = Start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state_q == RUN);
        Done = (state_q == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else if (load_op) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            acc_q    <= acc_d;
            borrow_q <= c[4];
            cnt_q    <= cnt_q + CW'(1);
            if (last_nib) begin
                diff_q <= acc_d;
                bout_q <= c[4];
                zero_q <= (acc_d == '0);
            end
        end
    end

`ifdef SUB_OVERFLOW_EN
    logic ovf_q;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            ovf_q <= 1'b0;
        else if (!load_op && state_q == RUN && last_nib)
            ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
    end
    assign Ovf = ovf_q;
`endif

    assign Diff = diff_q;
    assign Bout = bout_q;
    assign Zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH=16) against an arithmetic reference model.
module tb_nibble_serial_subtractor;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk, rst, start, bin;
    logic [W-1:0] a, b, diff;
    logic         bout, zero, busy, done;
`ifdef SUB_OVERFLOW_EN
    logic         ovf;
`endif

    int vectors    = 0;
    int miscompares = 0;

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .Clk   (clk),
        .Reset (rst),
        .Start (start),
        .A     (a),
        .B     (b),
        .Bin   (bin),
        .Diff  (diff),
        .Bout  (bout),
        .Zero  (zero),
        .Busy  (busy),
        .Done  (done)
`ifdef SUB_OVERFLOW_EN
        ,
        .Ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation: Start at the next edge, operands scrambled and spurious Start during RUN,
    // then Busy for NIB cycles and a Done cycle carrying the model's result.
    task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input logic op_bin, input string tag);
        logic [W:0]   full;
        logic [W-1:0] exp_diff;
        full     = {1'b0, op_a} - {1'b0, op_b} - {{W{1'b0}}, op_bin};
        exp_diff = full[W-1:0];
        a = op_a; b = op_b; bin = op_bin; start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NIB; i++) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            start = (i < NIB - 1) ? 1'($urandom) : 1'b0;
            @(negedge clk);
            check({tag, " busy"}, W'(busy), W'(1));
            check({tag, " done_early"}, W'(done), W'(0));
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, " done"}, W'(done), W'(1));
        check({tag, " busy_end"}, W'(busy), W'(0));
        check({tag, " diff"}, diff, exp_diff);
        check({tag, " bout"}, W'(bout), W'(full[W]));
        check({tag, " zero"}, W'(zero), W'(exp_diff == '0));
`ifdef SUB_OVERFLOW_EN
        check({tag, " ovf"}, W'(ovf),
              W'((op_a[W-1] != op_b[W-1]) && (exp_diff[W-1] != op_a[W-1])));
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #2;
        check("rst diff", diff, '0);
        check("rst bout", W'(bout), W'(0));
        check("rst zero", W'(zero), W'(0));
        check("rst busy", W'(busy), W'(0));
        check("rst done", W'(done), W'(0));
`ifdef SUB_OVERFLOW_EN
        check("rst ovf", W'(ovf), W'(0));
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(16'h1234, 16'h0234, 1'b0, "basic");
        check("basic const", diff, 16'h1000);
        do_op(16'h0000, 16'h0001, 1'b0, "underflow");
        check("underflow const", diff, 16'hFFFF);
        do_op(16'h8000, 16'h0001, 1'b0, "sgn_ovf");
        check("sgn_ovf const", diff, 16'h7FFF);
        do_op(16'h0010, 16'h000F, 1'b1, "nib_borrow");
        check("nib_borrow zero", W'(zero), W'(1));
        do_op(16'hFFFF, 16'hFFFF, 1'b1, "all_ones_bin");
        do_op(16'h0000, 16'h0000, 1'b0, "zeros");

        for (int n = 0; n < 24; n++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), "random");

        // Start held high: Done on every 5th negedge, A disturbed mid-RUN.
        @(negedge clk);
        a = 16'h5555; b = 16'h1111; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            if (cyc % 5 == 2) a = 16'hFFFF;
            if (cyc % 5 == 4) a = 16'h5555;
            if (cyc == 15) start = 1'b0;
            check("held busy", W'(busy), W'(cyc % 5 != 0));
            check("held done", W'(done), W'(cyc % 5 == 0));
            if (cyc % 5 == 0) check("held diff", diff, 16'h4444);
        end

        // Reset asserted in the second RUN cycle aborts the operation immediately.
        @(negedge clk);
        a = 16'h9876; b = 16'h0123; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort diff", diff, '0);
        check("abort bout", W'(bout), W'(0));
        check("abort zero", W'(zero), W'(0));
        check("abort busy", W'(busy), W'(0));
        check("abort done", W'(done), W'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_abort done", W'(done), W'(0));
            check("post_abort busy", W'(busy), W'(0));
        end
        do_op(16'h0003, 16'h0005, 1'b0, "after_abort");
        check("after_abort const", diff, 16'hFFFE);
        check("after_abort bout", W'(bout), W'(1));

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
